// File: rtl/alu_ctrl_pkg.sv
// rtl/alu_ctrl_pkg.sv - shared opcodes, FSM states and flag bit positions for the ALU sequencer
package alu_ctrl_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_NOT = 4'd5;
    localparam logic [3:0] OP_SHL = 4'd6;
    localparam logic [3:0] OP_SHR = 4'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam int FLG_C = 3;
    localparam int FLG_V = 2;
    localparam int FLG_N = 1;
    localparam int FLG_Z = 0;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - combinational 2-way round-robin arbiter; i_ptr is the last granted requester
module rr_arb2 (
    input  logic [1:0] i_req,
    input  logic       i_ptr,
    output logic [1:0] o_gnt
);

    always_comb begin
        o_gnt = 2'b00;
        case (i_req)
            2'b01:   o_gnt = 2'b01;
            2'b10:   o_gnt = 2'b10;
            2'b11:   o_gnt = i_ptr ? 2'b01 : 2'b10;
            default: o_gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/alu_rr_sequencer.sv
// rtl/alu_rr_sequencer.sv - shares one external ALU between two requesters with round-robin grant
module alu_rr_sequencer
    import alu_ctrl_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int OP_W    = 4,
    parameter int NUM_OPS = 8,
    parameter int CNT_W   = 16
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [1:0]          i_req_valid,
    output logic [1:0]          o_req_ready,
    input  logic [2*OP_W-1:0]   i_req_op,
    input  logic [2*DATA_W-1:0] i_req_a,
    input  logic [2*DATA_W-1:0] i_req_b,
    output logic [DATA_W-1:0]   o_alu_a,
    output logic [DATA_W-1:0]   o_alu_b,
    output logic [OP_W-1:0]     o_alu_sel,
    input  logic [DATA_W-1:0]   i_alu_s,
    input  logic [3:0]          i_alu_flags,
    output logic                o_rsp_valid,
    input  logic                i_rsp_ready,
    output logic                o_rsp_id,
    output logic [DATA_W-1:0]   o_rsp_s,
    output logic [3:0]          o_rsp_flags,
    output logic                o_rsp_err,
    output logic [CNT_W-1:0]    o_op_count
);

    state_t              r_state;
    logic                r_ptr;
    logic                r_id;
    logic                r_err;
    logic [DATA_W-1:0]   r_alu_a;
    logic [DATA_W-1:0]   r_alu_b;
    logic [OP_W-1:0]     r_alu_sel;
    logic                r_rsp_valid;
    logic                r_rsp_id;
    logic [DATA_W-1:0]   r_rsp_s;
    logic [3:0]          r_rsp_flags;
    logic                r_rsp_err;
    logic [CNT_W-1:0]    r_op_count;

    logic [1:0]          w_gnt;
    logic                w_fire;
    logic                w_sel;
    logic [OP_W-1:0]     w_op;
    logic [DATA_W-1:0]   w_a;
    logic [DATA_W-1:0]   w_b;
    logic                w_illegal;

    rr_arb2 u_arb (
        .i_req (i_req_valid),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt)
    );

    // Ready is gated by reset so a held valid cannot appear accepted while aborting.
    assign o_req_ready = (r_state == ST_IDLE && !i_rst) ? w_gnt : 2'b00;
    assign w_fire      = |(i_req_valid & o_req_ready);
    assign w_sel       = w_gnt[1];
    assign w_op        = w_sel ? i_req_op[2*OP_W-1:OP_W]     : i_req_op[OP_W-1:0];
    assign w_a         = w_sel ? i_req_a[2*DATA_W-1:DATA_W]  : i_req_a[DATA_W-1:0];
    assign w_b         = w_sel ? i_req_b[2*DATA_W-1:DATA_W]  : i_req_b[DATA_W-1:0];
    assign w_illegal   = int'(w_op) >= NUM_OPS;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_ptr       <= 1'b1;
            r_id        <= 1'b0;
            r_err       <= 1'b0;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_alu_sel   <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= 1'b0;
            r_rsp_s     <= '0;
            r_rsp_flags <= '0;
            r_rsp_err   <= 1'b0;
            r_op_count  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_fire) begin
                        r_alu_a   <= w_a;
                        r_alu_b   <= w_b;
                        r_alu_sel <= w_illegal ? OP_W'(OP_ADD) : w_op;
                        r_err     <= w_illegal;
                        r_id      <= w_sel;
                        r_ptr     <= w_sel;
                        r_state   <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    r_rsp_id    <= r_id;
                    r_rsp_err   <= r_err;
                    r_rsp_s     <= r_err ? '0 : i_alu_s;
                    r_rsp_flags <= r_err ? 4'b0000 : i_alu_flags;
                    r_rsp_valid <= 1'b1;
                    r_state     <= ST_RESP;
                end
                ST_RESP: begin
                    if (i_rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_op_count  <= r_op_count + CNT_W'(1);
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_alu_a     = r_alu_a;
    assign o_alu_b     = r_alu_b;
    assign o_alu_sel   = r_alu_sel;
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_id    = r_rsp_id;
    assign o_rsp_s     = r_rsp_s;
    assign o_rsp_flags = r_rsp_flags;
    assign o_rsp_err   = r_rsp_err;
    assign o_op_count  = r_op_count;

endmodule

// File: tb/tb_alu_rr_sequencer.sv
// tb/tb_alu_rr_sequencer.sv - scoreboard bench for alu_rr_sequencer with a behavioural ALU
module tb_alu_rr_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [7:0]  req_op;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [3:0]  alu_sel;
    logic [7:0]  alu_s;
    logic [3:0]  alu_flags;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [7:0]  rsp_s;
    logic [3:0]  rsp_flags;
    logic        rsp_err;
    logic [15:0] op_count;

    always #5 clk = ~clk;

    alu_rr_sequencer dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_req_valid (req_valid),
        .o_req_ready (req_ready),
        .i_req_op    (req_op),
        .i_req_a     (req_a),
        .i_req_b     (req_b),
        .o_alu_a     (alu_a),
        .o_alu_b     (alu_b),
        .o_alu_sel   (alu_sel),
        .i_alu_s     (alu_s),
        .i_alu_flags (alu_flags),
        .o_rsp_valid (rsp_valid),
        .i_rsp_ready (rsp_ready),
        .o_rsp_id    (rsp_id),
        .o_rsp_s     (rsp_s),
        .o_rsp_flags (rsp_flags),
        .o_rsp_err   (rsp_err),
        .o_op_count  (op_count)
    );

    logic [8:0] m_t;
    logic       m_v;
    always_comb begin
        m_t = 9'd0;
        m_v = 1'b0;
        case (alu_sel)
            4'd0: begin
                m_t = {1'b0, alu_a} + {1'b0, alu_b};
                m_v = (alu_a[7] == alu_b[7]) && (m_t[7] != alu_a[7]);
            end
            4'd1: begin
                m_t = {1'b0, alu_a} - {1'b0, alu_b};
                m_v = (alu_a[7] != alu_b[7]) && (m_t[7] != alu_a[7]);
            end
            4'd2: m_t = {1'b0, alu_a & alu_b};
            4'd3: m_t = {1'b0, alu_a | alu_b};
            4'd4: m_t = {1'b0, alu_a ^ alu_b};
            4'd5: m_t = {1'b0, ~alu_a};
            4'd6: m_t = {alu_a, 1'b0};
            4'd7: m_t = {alu_a[0], 1'b0, alu_a[7:1]};
            default: m_t = 9'h1EE;
        endcase
        alu_s     = m_t[7:0];
        alu_flags = (alu_sel > 4'd7) ? 4'hF : {m_t[8], m_v, m_t[7], (m_t[7:0] == 8'h00)};
    end

    typedef struct {
        logic       id;
        logic [7:0] s;
        logic [3:0] f;
        logic       err;
        int         acc;
    } exp_t;

    typedef struct {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] s;
        logic [3:0] f;
        logic       err;
    } vec_t;

    exp_t q[$];
    vec_t p0[4];
    vec_t p1[4];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    int   done   = 0;
    logic last   = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input logic id, input logic [7:0] s, input logic [3:0] f, input logic err);
        exp_t e;
        e.id  = id;
        e.s   = s;
        e.f   = f;
        e.err = err;
        e.acc = cyc;
        q.push_back(e);
        last = id;
    endtask

    task automatic issue(input int r, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] s, input logic [3:0] f, input logic err);
        int n = 0;
        req_op[r*4 +: 4] = op;
        req_a[r*8 +: 8]  = a;
        req_b[r*8 +: 8]  = b;
        req_valid[r]     = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready[r] && n < 50);
        chk("accept_wait", (n < 50) ? 1 : 0, 1);
        if (req_ready[r]) push_exp(r[0], s, f, err);
        @(posedge clk) #1;
        req_valid[r] = 1'b0;
        @(negedge clk);
        chk("exec_alu_sel", alu_sel, err ? 4'd0 : op);
        chk("exec_alu_a", alu_a, a);
    endtask

    task automatic pair_run(input int n0, input int n1);
        int   i0 = 0;
        int   i1 = 0;
        int   n;
        logic g;
        req_op = {p1[0].op, p0[0].op};
        req_a  = {p1[0].a, p0[0].a};
        req_b  = {p1[0].b, p0[0].b};
        req_valid = {(n1 > 0), (n0 > 0)};
        while (i0 < n0 || i1 < n1) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (req_ready == 2'b00 && n < 50);
            chk("grant_wait", (n < 50) ? 1 : 0, 1);
            if (n >= 50) break;
            if (i0 < n0 && i1 < n1) g = ~last;
            else                    g = (i1 < n1);
            chk("grant", req_ready, g ? 2'b10 : 2'b01);
            if (g) push_exp(1'b1, p1[i1].s, p1[i1].f, p1[i1].err);
            else   push_exp(1'b0, p0[i0].s, p0[i0].f, p0[i0].err);
            @(posedge clk) #1;
            if (g) begin
                i1++;
                if (i1 < n1) begin
                    req_op[7:4] = p1[i1].op; req_a[15:8] = p1[i1].a; req_b[15:8] = p1[i1].b;
                end else req_valid[1] = 1'b0;
            end else begin
                i0++;
                if (i0 < n0) begin
                    req_op[3:0] = p0[i0].op; req_a[7:0] = p0[i0].a; req_b[7:0] = p0[i0].b;
                end else req_valid[0] = 1'b0;
            end
        end
        req_valid = 2'b00;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain", q.size(), 0);
        @(posedge clk) #1;
    endtask

    initial begin : monitor
        logic prev = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev = 1'b0;
            end else begin
                if (rsp_valid && !prev) begin
                    if (q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_rsp: got rsp_valid=1 expected no response");
                    end else chk("latency", cyc, q[0].acc + 2);
                end
                if (rsp_valid && rsp_ready && q.size() != 0) begin
                    e = q.pop_front();
                    chk("rsp_id", rsp_id, e.id);
                    chk("rsp_s", rsp_s, e.s);
                    chk("rsp_flags", rsp_flags, e.f);
                    chk("rsp_err", rsp_err, e.err);
                    chk("op_count", op_count, done);
                    done++;
                end
                prev = rsp_valid;
            end
        end
    end

    initial begin
        rst = 1'b1; req_valid = 2'b00; req_op = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_payload", {rsp_id, rsp_err, rsp_s, rsp_flags}, 0);
        chk("rst_alu", {alu_a, alu_b, alu_sel}, 0);
        chk("rst_op_count", op_count, 0);
        @(posedge clk) #1;
        rst = 1'b0;

        issue(0, 4'd0, 8'h7F, 8'h01, 8'h80, 4'b0110, 1'b0);
        drain();
        issue(1, 4'd1, 8'h03, 8'h05, 8'hFE, 4'b1010, 1'b0);
        drain();
        issue(1, 4'd1, 8'h05, 8'h05, 8'h00, 4'b0001, 1'b0);
        drain();

        p0[0] = '{4'd0, 8'h01, 8'h02, 8'h03, 4'b0000, 1'b0};
        p0[1] = '{4'd2, 8'hF0, 8'h3C, 8'h30, 4'b0000, 1'b0};
        p0[2] = '{4'd3, 8'h0F, 8'hF0, 8'hFF, 4'b0010, 1'b0};
        p0[3] = '{4'd4, 8'hAA, 8'hAA, 8'h00, 4'b0001, 1'b0};
        p1[0] = '{4'd5, 8'h0F, 8'h00, 8'hF0, 4'b0010, 1'b0};
        p1[1] = '{4'd6, 8'h81, 8'h00, 8'h02, 4'b1000, 1'b0};
        p1[2] = '{4'd7, 8'h01, 8'h00, 8'h00, 4'b1001, 1'b0};
        p1[3] = '{4'd1, 8'h80, 8'h01, 8'h7F, 4'b0100, 1'b0};
        pair_run(4, 4);
        drain();
        chk("op_count_after_pairs", op_count, 11);

        issue(0, 4'hA, 8'h10, 8'h20, 8'h00, 4'b0000, 1'b1);
        drain();

        rsp_ready = 1'b0;
        issue(0, 4'd0, 8'h22, 8'h11, 8'h33, 4'b0000, 1'b0);
        @(posedge clk) #1;
        req_op[7:4] = 4'd4; req_a[15:8] = 8'h0F; req_b[15:8] = 8'hFF; req_valid[1] = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("stall_rsp_valid", rsp_valid, 1);
            chk("stall_rsp_s", rsp_s, 8'h33);
            chk("stall_req_ready", req_ready, 0);
        end
        @(posedge clk) #1;
        rsp_ready = 1'b1;
        issue(1, 4'd4, 8'h0F, 8'hFF, 8'hF0, 4'b0010, 1'b0);
        drain();

        issue(0, 4'd3, 8'h01, 8'h02, 8'h03, 4'b0000, 1'b0);
        #1;
        rst = 1'b1;
        req_valid = 2'b11;
        #1;
        chk("arst_req_ready", req_ready, 0);
        chk("arst_rsp_valid", rsp_valid, 0);
        chk("arst_alu", {alu_a, alu_b, alu_sel}, 0);
        chk("arst_rsp_payload", {rsp_id, rsp_err, rsp_s, rsp_flags}, 0);
        chk("arst_op_count", op_count, 0);
        q.delete();
        done = 0;
        last = 1'b1;
        @(posedge clk) #1;
        rst = 1'b0;
        p0[0] = '{4'd0, 8'h40, 8'h40, 8'h80, 4'b0110, 1'b0};
        p1[0] = '{4'd2, 8'hFF, 8'h0F, 8'h0F, 4'b0000, 1'b0};
        pair_run(1, 1);
        drain();

        chk("queue_empty", q.size(), 0);
        chk("final_op_count", op_count, done);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
